// File: rtl/rxdata.sv
// ASCII "0x<hex>" line decoder; o_stb/o_err register one cycle after the deciding byte.
// Accepts a byte on every i_stb with no backpressure; o_data holds the last good word.
module rxdata #(
  parameter int NDIGITS = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_stb,
  input  logic [7:0]           i_byte,
  output logic                 o_stb,
  output logic [4*NDIGITS-1:0] o_data,
  output logic                 o_err
);

  localparam int W  = 4 * NDIGITS;
  localparam int CW = $clog2(NDIGITS + 1);

  typedef enum logic [1:0] {S_IDLE, S_X, S_DIGIT, S_ERR} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stb_q, stb_d;
  logic          err_q, err_d;

  logic          is_hex;
  logic          is_term;
  logic [3:0]    nib;

  always_comb begin
    is_hex  = 1'b1;
    nib     = 4'd0;
    is_term = (i_byte == 8'h0d) || (i_byte == 8'h0a);
    if (i_byte >= 8'h30 && i_byte <= 8'h39) begin
      nib = i_byte[3:0];
    end else if ((i_byte >= 8'h61 && i_byte <= 8'h66) ||
                 (i_byte >= 8'h41 && i_byte <= 8'h46)) begin
      // 'a'/'A' have low nibble 1, so +9 maps them onto 10..15
      nib = i_byte[3:0] + 4'd9;
    end else begin
      is_hex = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    stb_d   = 1'b0;
    err_d   = 1'b0;
    if (i_stb) begin
      unique case (state_q)
        S_IDLE: begin
          if (i_byte == 8'h30) begin
            state_d = S_X;
          end else if (!is_term) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
        S_X: begin
          if (i_byte == 8'h78 || i_byte == 8'h58) begin
            state_d = S_DIGIT;
            acc_d   = '0;
            cnt_d   = '0;
          end else if (is_term) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
        S_DIGIT: begin
          if (is_hex && cnt_q < CW'(NDIGITS)) begin
            acc_d = {acc_q[W-5:0], nib};
            cnt_d = cnt_q + CW'(1);
          end else if (is_term) begin
            state_d = S_IDLE;
            if (cnt_q != '0) begin
              data_d = acc_q;
              stb_d  = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            // Covers both non-digit bytes and a digit beyond NDIGITS
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
        S_ERR: begin
          if (is_term) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      stb_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      stb_q   <= stb_d;
      err_q   <= err_d;
    end
  end

  assign o_stb  = stb_q;
  assign o_err  = err_q;
  assign o_data = data_q;

endmodule

// File: tb/tb_rxdata.sv
// Self-checking bench for rxdata: scoreboard of expected words plus per-scenario checks.
module tb_rxdata;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_stb = 1'b0;
  logic [7:0]  i_byte = 8'h00;
  logic        o_stb;
  logic [31:0] o_data;
  logic        o_err;

  int checks = 0;
  int errors = 0;
  int n_stb  = 0;
  int n_err  = 0;
  logic [31:0] exp_q[$];

  rxdata #(.NDIGITS(8)) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_stb  (i_stb),
    .i_byte (i_byte),
    .o_stb  (o_stb),
    .o_data (o_data),
    .o_err  (o_err)
  );

  always #5 i_clk = ~i_clk;

  // Scoreboard side: every o_stb must match the oldest expected word
  always @(negedge i_clk) begin
    if (o_stb) begin
      n_stb++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_stb data=%h expected no strobe", o_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (o_data !== e) begin
          errors++;
          $display("FAIL sb_data got=%h exp=%h", o_data, e);
        end
      end
    end
    if (o_err) n_err++;
    if (o_stb && o_err) begin
      checks++;
      errors++;
      $display("FAIL stb_err_overlap stb=%b err=%b exp=not both", o_stb, o_err);
    end
  end

  // Bytes go out on negedges; after the last byte the task returns on the
  // negedge following the capturing posedge, where the pulse is visible.
  task automatic send_str(input string s, input int maxgap);
    for (int i = 0; i < s.len(); i++) begin
      i_stb  = 1'b1;
      i_byte = s[i];
      @(negedge i_clk);
      i_stb = 1'b0;
      if (maxgap > 0) repeat ($urandom_range(maxgap, 0)) @(negedge i_clk);
    end
  endtask

  task automatic settle();
    repeat (3) @(negedge i_clk);
  endtask

  task automatic check_counts(input string name, input int s0, input int e0,
                              input int ds, input int de);
    checks++;
    if (n_stb - s0 != ds || n_err - e0 != de) begin
      errors++;
      $display("FAIL %s stb=%0d err=%0d exp stb=%0d err=%0d",
               name, n_stb - s0, n_err - e0, ds, de);
    end
  endtask

  task automatic check_data(input string name, input logic [31:0] e);
    checks++;
    if (o_data !== e) begin
      errors++;
      $display("FAIL %s data=%h exp=%h", name, o_data, e);
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (2) @(negedge i_clk);
    checks++;
    if (o_stb !== 1'b0 || o_err !== 1'b0 || o_data !== 32'h0) begin
      errors++;
      $display("FAIL reset stb=%b err=%b data=%h exp 0/0/0", o_stb, o_err, o_data);
    end
    i_reset = 1'b0;
    settle();
    check_counts("reset_idle", 0, 0, 0, 0);
  endtask

  task automatic test_valid();
    int s0 = n_stb, e0 = n_err;
    exp_q.push_back(32'h1234ABCD);
    send_str("0x1234ABCD\n", 0);
    checks++;
    if (o_stb !== 1'b1 || o_data !== 32'h1234ABCD) begin
      errors++;
      $display("FAIL valid_latency stb=%b data=%h exp 1/1234abcd", o_stb, o_data);
    end
    @(negedge i_clk);
    checks++;
    if (o_stb !== 1'b0) begin
      errors++;
      $display("FAIL valid_one_cycle stb=%b exp 0", o_stb);
    end
    settle();
    check_counts("valid_counts", s0, e0, 1, 0);
  endtask

  task automatic test_short_case();
    int s0 = n_stb, e0 = n_err;
    exp_q.push_back(32'h0000000F);
    send_str("0Xf\015\n", 0);
    settle();
    check_counts("short_counts", s0, e0, 1, 0);
    check_data("short_data", 32'h0000000F);
  endtask

  task automatic test_overflow();
    int s0 = n_stb, e0 = n_err;
    send_str("0x123456789", 0);
    checks++;
    if (o_err !== 1'b1) begin
      errors++;
      $display("FAIL overflow_latency err=%b exp 1", o_err);
    end
    send_str("\n", 0);
    settle();
    check_counts("overflow_counts", s0, e0, 0, 1);
    check_data("overflow_hold", 32'h0000000F);
    s0 = n_stb;
    e0 = n_err;
    exp_q.push_back(32'h5);
    send_str("0x5\n", 0);
    settle();
    check_counts("after_overflow_counts", s0, e0, 1, 0);
    check_data("after_overflow_data", 32'h5);
  endtask

  task automatic test_bad_lines();
    string bad[3] = '{"12\n", "0xG1\n", "0x\n"};
    for (int i = 0; i < 3; i++) begin
      int s0 = n_stb, e0 = n_err;
      send_str(bad[i], 0);
      settle();
      check_counts($sformatf("bad_%0d_counts", i), s0, e0, 0, 1);
      check_data($sformatf("bad_%0d_hold", i), 32'h5);
    end
  endtask

  task automatic test_gapped();
    int s0 = n_stb, e0 = n_err;
    exp_q.push_back(32'h0000BEEF);
    send_str("0xBEEF\n", 3);
    settle();
    check_counts("gapped_counts", s0, e0, 1, 0);
    check_data("gapped_data", 32'h0000BEEF);
  endtask

  task automatic test_reset_midline();
    int s0 = n_stb, e0 = n_err;
    send_str("0x12", 0);
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    exp_q.push_back(32'h34);
    send_str("0x34\n", 0);
    settle();
    check_counts("midreset_counts", s0, e0, 1, 0);
    check_data("midreset_data", 32'h34);
  endtask

  task automatic test_back_to_back();
    int s0 = n_stb, e0 = n_err;
    exp_q.push_back(32'h0000000A);
    exp_q.push_back(32'hFEDCBA98);
    send_str("0xa\n0xFEDCBA98\n", 0);
    settle();
    check_counts("b2b_counts", s0, e0, 2, 0);
    check_data("b2b_data", 32'hFEDCBA98);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover remaining=%0d exp=0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_valid();
    test_short_case();
    test_overflow();
    test_bad_lines();
    test_gapped();
    test_reset_midline();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rxdata.md
Name: rxdata

Overview:
- ASCII hex-word decoder; receive-side counterpart of the hex-word transmitter.
- Consumes one byte per strobe from the UART receiver.
- Parses lines of the form "0x" + 1..NDIGITS hex digits + CR or LF.
- Emits the decoded word with a one-cycle strobe; drives counter preload / debug registers from a host terminal.

Parameters:
- NDIGITS, 8, maximum number of hex digits per word; o_data width = 4*NDIGITS.

Ports:
- i_clk  input  1  system clock
- i_reset  input  1  synchronous, active-high reset
- i_stb  input  1  i_byte valid this cycle (single-cycle pulse per received byte)
- i_byte  input  8  received ASCII byte
- o_stb  output  1  one-cycle pulse: o_data holds a newly decoded word
- o_data  output  4*NDIGITS  last successfully decoded word
- o_err  output  1  one-cycle pulse: current line is malformed

Behaviour:
- Clock i_clk; reset i_reset, synchronous, active-high.
- Reset values: o_stb=0, o_err=0, o_data=0, state=S_IDLE, accumulator=0, digit count=0.
- Reset mid-line discards the partial line. No o_stb/o_err is generated for the discarded line.
- When i_stb=0, all state holds; o_stb and o_err are 0.
- Hex digits: '0'-'9' (0x30-0x39), 'a'-'f' (0x61-0x66), 'A'-'F' (0x41-0x46). Any other byte is a non-digit.
- Terminator: CR (0x0D) or LF (0x0A).
- States and transitions (all evaluated on cycles with i_stb=1):
  - S_IDLE:
    - '0' -> S_X.
    - Terminator -> stay (blank lines and CR+LF pairs are silent).
    - Other byte -> S_ERR, o_err pulse.
  - S_X:
    - 'x' or 'X' -> S_DIGIT; accumulator=0, count=0.
    - Terminator -> S_IDLE, o_err pulse.
    - Other byte -> S_ERR, o_err pulse.
  - S_DIGIT, hex digit with count<NDIGITS -> stay; accumulator={accumulator[4*NDIGITS-5:0], nibble}; count+1.
  - S_DIGIT, hex digit with count==NDIGITS -> S_ERR, o_err pulse (overflow).
  - S_DIGIT, terminator with count>=1 -> S_IDLE; o_data<=accumulator; o_stb pulse.
  - S_DIGIT, terminator with count==0 -> S_IDLE, o_err pulse.
  - S_DIGIT, other byte -> S_ERR, o_err pulse.
  - S_ERR:
    - Terminator -> S_IDLE, no pulse.
    - Other byte -> stay, no pulse.
- Result is right-aligned: fewer than NDIGITS digits zero-extend in the upper bits ("0x1F" -> 0x0000001F).
- Latency: o_stb/o_err assert on the clock edge after the i_stb cycle carrying the deciding byte, for exactly one cycle.
- o_data updates only on successful termination and holds otherwise, including across errors.
- o_err pulses at most once per malformed line.
- o_stb and o_err are never high in the same cycle.
- Back-to-back strobes on consecutive cycles are accepted; no backpressure and no bytes dropped.
- Count register width is clog2(NDIGITS+1) bits.

Test Plan:
- Valid line: bytes "0x1234ABCD\n" on consecutive cycles -> one cycle after '\n': o_stb=1 and o_data=0x1234ABCD; o_err stays 0 throughout.
- Short word and case mix: "0Xf\r\n" -> o_data=0x0000000F, single o_stb; the trailing LF produces no pulse.
- Overflow: "0x123456789\n" -> o_err pulse one cycle after '9'; no o_stb; o_data keeps its previous value. A following "0x5\n" -> o_data=0x5.
- Bad prefix / bad digit / empty: "12\n", "0xG1\n", "0x\n" -> exactly one o_err each, zero o_stb; o_data unchanged.
- Gapped strobes: "0xBEEF\n" with 0-3 idle cycles (i_stb=0) between bytes -> o_data=0x0000BEEF, same result as back-to-back.
- Reset mid-line: send "0x12", assert i_reset one cycle, then "0x34\n" -> o_data=0x34; no o_err; exactly one o_stb.
